// File: rtl/emif_dpram_arbiter.sv
// Shares one single-port DPRAM. EMIF takes the port first with no added latency; queued local
// commands issue in idle slots, and a local read answers one cycle after it issues. usr_cmd_ready drops only while the FIFO is full.
module emif_dpram_arbiter #(
  parameter int          ADDR_W       = 10,
  parameter int          DATA_W       = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] STARVE_LIMIT = 16'd1000
) (
  input  logic                            clk_ref,
  input  logic                            rst,
  input  logic                            emif_dpram_wen,
  input  logic                            emif_dpram_ren_2,
  input  logic [23:0]                     emif_dpram_addr,
  input  logic [DATA_W-1:0]               emif_dpram_wdata,
  output logic [DATA_W-1:0]               emif_dpram_rdata,
  input  logic                            usr_cmd_valid,
  output logic                            usr_cmd_ready,
  input  logic                            usr_cmd_we,
  input  logic [ADDR_W-1:0]               usr_cmd_addr,
  input  logic [DATA_W-1:0]               usr_cmd_wdata,
  output logic                            usr_rsp_valid,
  output logic [DATA_W-1:0]               usr_rsp_data,
  output logic                            ram_en,
  output logic                            ram_we,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic [DATA_W-1:0]               ram_wdata,
  input  logic [DATA_W-1:0]               ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            starve_flag,
  output logic                            emif_collide
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t              mem_q [FIFO_DEPTH];
  cmd_t              mem_d [FIFO_DEPTH];
  cmd_t              head;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              starve_q, starve_d;
  logic              rsp_pend_q, rsp_pend_d;
  logic              collide_q, collide_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              emif_act, empty, push, issue;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^emif_dpram_addr[23:ADDR_W];

  assign emif_act      = emif_dpram_wen | emif_dpram_ren_2;
  assign empty         = (level_q == '0);
  assign usr_cmd_ready = (level_q != FULL_LVL);
  assign push          = usr_cmd_valid & usr_cmd_ready;
  assign head          = mem_q[rd_ptr_q];
  // Local issue is suppressed during reset so a flushed head never reaches the RAM.
  assign issue         = !rst && !emif_act && !empty;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = ram_addr_q;
    ram_wdata = ram_wdata_q;
    if (emif_act) begin
      ram_en    = 1'b1;
      ram_we    = emif_dpram_wen;
      ram_addr  = emif_dpram_addr[ADDR_W-1:0];
      ram_wdata = emif_dpram_wdata;
    end else if (issue) begin
      ram_en    = 1'b1;
      ram_we    = head.we;
      ram_addr  = head.addr;
      ram_wdata = head.wdata;
    end
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{we: usr_cmd_we, addr: usr_cmd_addr, wdata: usr_cmd_wdata};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, issue})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    if (empty || issue)            cnt_d = '0;
    else if (cnt_q == STARVE_LIMIT) cnt_d = cnt_q;
    else                           cnt_d = cnt_q + 16'd1;
    starve_d   = (cnt_d == STARVE_LIMIT);
    rsp_pend_d = issue && !head.we;
    collide_d  = collide_q | (emif_dpram_wen & emif_dpram_ren_2);
  end

  // Command storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk_ref) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      starve_q    <= 1'b0;
      rsp_pend_q  <= 1'b0;
      collide_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      rsp_pend_q  <= rsp_pend_d;
      collide_q   <= collide_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign usr_rsp_valid    = rsp_pend_q && !rst;
  assign usr_rsp_data     = usr_rsp_valid ? ram_rdata : '0;
  assign emif_dpram_rdata = ram_rdata;
  assign fifo_level       = level_q;
  assign starve_flag      = starve_q;
  assign emif_collide     = collide_q;

endmodule

// File: doc/emif_dpram_arbiter.md
# emif_dpram_arbiter

Shares one single-port DPRAM between the EMIF bridge's user-DPRAM port and a local FPGA-side requester. EMIF accesses have absolute priority and pass through with zero added latency. Local commands are buffered in a small FIFO and issued in slots the EMIF leaves idle. Read data is returned in order, and a starvation monitor flags local commands that are blocked for too long. Sits between the EMIF bridge's emif_dpram_* outputs and the RAM primitive.

## Interface
- ADDR_W, 10: RAM address width; EMIF address bits [ADDR_W-1:0] are used, upper bits ignored.
- DATA_W, 16: data width.
- FIFO_DEPTH, 4: local command FIFO depth; power of two, ≥2.
- STARVE_LIMIT, 16'd1000: blocked-head cycle count at which starve_flag sets.

- clk_ref  in  1  single clock for all logic.
- rst  in  1  reset; synchronous, active-high.
- emif_dpram_wen  in  1  EMIF write strobe, 1-cycle pulse.
- emif_dpram_ren_2  in  1  EMIF read enable, 2-cycle pulse, same address both cycles.
- emif_dpram_addr  in  24  EMIF address.
- emif_dpram_wdata  in  DATA_W  EMIF write data.
- emif_dpram_rdata  out  DATA_W  read data to EMIF; equals ram_rdata.
- usr_cmd_valid  in  1  local command valid.
- usr_cmd_ready  out  1  FIFO can accept a command (= !full).
- usr_cmd_we  in  1  1 = write, 0 = read.
- usr_cmd_addr  in  ADDR_W  local address.
- usr_cmd_wdata  in  DATA_W  local write data.
- usr_rsp_valid  out  1  local read data valid, 1-cycle pulse.
- usr_rsp_data  out  DATA_W  local read data.
- ram_en, ram_we  out  1  RAM port enable / write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; 1-cycle registered latency after ram_en with !ram_we.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  commands currently queued.
- starve_flag  out  1  local head blocked ≥ STARVE_LIMIT cycles.
- emif_collide  out  1  sticky error: emif_dpram_wen and emif_dpram_ren_2 were high in the same cycle.

## Operation
- Port ownership is decided combinationally each cycle:
  - EMIF owns the port if emif_dpram_wen | emif_dpram_ren_2 is high.
  - Otherwise the FIFO head owns it if the FIFO is non-empty.
  - Otherwise the port is idle.
- EMIF owner:
  - ram_en=1, ram_we=emif_dpram_wen, ram_addr=emif_dpram_addr[ADDR_W-1:0], ram_wdata=emif_dpram_wdata.
  - If wen and ren_2 are both high, the write wins and emif_collide sets.
- Local owner: ram_* is driven from the FIFO head, and the head is popped the same cycle (the issue cycle).
- Idle: ram_en=0, ram_we=0; ram_addr and ram_wdata hold their last values.
- Response tag: a register captures "local read issued" each cycle. When set, the next cycle drives usr_rsp_valid=1 with usr_rsp_data=ram_rdata.
- emif_dpram_rdata is driven from ram_rdata at all times. The EMIF bridge samples it inside its own 2-cycle ren window.
- FIFO:
  - Push when usr_cmd_valid & usr_cmd_ready.
  - usr_cmd_ready is !full with no same-cycle pop bypass, so a full FIFO stays not-ready even in a pop cycle.
  - A push into an empty FIFO cannot issue before the next cycle.
  - Simultaneous push and pop leave fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Starvation counter (16-bit):
  - Counts cycles where the FIFO is non-empty and the head is not issued.
  - Clears on issue or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - starve_flag = (count == STARVE_LIMIT), registered; clears the cycle after the counter clears.
- emif_collide clears only on rst.

## Timing
- Reset values: usr_cmd_ready=1 (after reset deasserts), usr_rsp_valid=0, usr_rsp_data=0, fifo_level=0, starve_flag=0, emif_collide=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - ram_en is 0 whenever the EMIF inputs are idle.
- Reset during operation flushes the FIFO, drops any pending response (no usr_rsp_valid afterwards), and clears the counter.
- EMIF path: 0 cycles in to ram_*. Read data is on ram_rdata in cycle t+1 for ren at t, and stays valid in cycle t+2 because of the second ren_2 cycle.
- Local path: accept at t; earliest issue at t+1; read response at issue+1.
- An EMIF burst blocks local issue for every cycle in which it is active. There is no local preemption.

## Test plan
- Local write then read: write 0x00A → 0xBEEF, then read 0x00A with no EMIF traffic → accept t, issue t+1, second command issues t+2, usr_rsp_valid at t+3 with 0xBEEF.
- EMIF priority: FIFO holds a read of 0x005; EMIF ren_2 high for cycles t, t+1 at 0x005 → local read issues at t+2; emif_dpram_rdata is valid at t+1 and t+2; usr_rsp_valid at t+3.
- Full FIFO: 4 pushes while EMIF is held busy → fifo_level=4 and ready=0; a pop cycle with valid high does not accept; ready=1 the cycle after level drops to 3.
- Starvation: STARVE_LIMIT=8, FIFO non-empty, EMIF busy 10 cycles → starve_flag rises after 8 blocked cycles and falls the cycle after the head issues.
- Collision: wen and ren_2 high together at 0x010 with wdata 0x1234 → RAM written with 0x1234 and emif_collide stays 1 until rst.
- Reset mid-read: rst asserted the cycle after a local read issue → no usr_rsp_valid, fifo_level=0.
